// File: rtl/count_checker.sv
// count_checker: verifies a qualified count bus increments by one each sample; COUNT_CHECKER_STUCK_EN adds a held-counter tolerance and a stuck output.
module count_checker #(
    parameter int WIDTH     = 32,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 count_valid,
    input  logic [WIDTH-1:0]     count_in,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected
`ifdef COUNT_CHECKER_STUCK_EN
    ,
    output logic                 stuck
`endif
);
    localparam int RW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    state_t          state;
    logic [RW-1:0]   run;
    logic [RW-1:0]   run_inc;
    logic            match;
    logic            hold_ok;
    logic [WIDTH-1:0] resync;

    assign run_inc = run + 1'b1;
    assign match   = count_in == expected;
    assign resync  = count_in + WIDTH'(1);

`ifdef COUNT_CHECKER_STUCK_EN
    // A repeat of the last accepted value while locked means the counter paused, not broke.
    assign hold_ok = state == LOCKED && count_in == expected - WIDTH'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            stuck <= 1'b0;
        else if (count_valid)
            stuck <= hold_ok;
`else
    assign hold_ok = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            expected  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (count_valid) begin
                case (state)
                    IDLE: begin
                        expected <= resync;
                        run      <= '0;
                        state    <= SYNC;
                    end
                    SYNC: begin
                        if (match) begin
                            expected <= expected + WIDTH'(1);
                            if (run_inc == RW'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            run      <= '0;
                            expected <= resync;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            expected <= expected + WIDTH'(1);
                        end else if (!hold_ok) begin
                            err_pulse <= 1'b1;
                            err_count <= err_count == '1 ? err_count : err_count + 1'b1;
                            state     <= SYNC;
                            locked    <= 1'b0;
                            run       <= '0;
                            expected  <= resync;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: table-driven directed check of count_checker plus hand sequences for async reset, saturation and held values.
module tb_count_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v = 1'b0, v2 = 1'b0;
    logic [31:0] d = '0, d2 = '0;
    logic        locked, err_pulse, locked2, err2;
    logic [15:0] err_count;
    logic [1:0]  cnt2;
    logic [31:0] expected, exp2;
`ifdef COUNT_CHECKER_STUCK_EN
    logic        stuck, stuck2;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_checker dut (
        .clk(clk), .rst(rst), .count_valid(v), .count_in(d),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
`ifdef COUNT_CHECKER_STUCK_EN
        , .stuck(stuck)
`endif
    );

    count_checker #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .count_valid(v2), .count_in(d2),
        .locked(locked2), .err_pulse(err2), .err_count(cnt2), .expected(exp2)
`ifdef COUNT_CHECKER_STUCK_EN
        , .stuck(stuck2)
`endif
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] d;
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [31:0] ex;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic vv, logic [31:0] dd, logic lk, logic ep, logic [15:0] ec, logic [31:0] ex);
        vec_t t;
        t.r = r; t.v = vv; t.d = dd; t.lk = lk; t.ep = ep; t.ec = ec; t.ex = ex;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic step(logic vv, logic [31:0] dd);
        @(negedge clk);
        v = vv;
        d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(logic [31:0] dd);
        @(negedge clk);
        v2 = 1'b1;
        d2 = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("reset locked", 32'(locked), 0);
        chk("reset err_pulse", 32'(err_pulse), 0);
        chk("reset err_count", 32'(err_count), 0);
        chk("reset expected", expected, 0);

        tbl.push_back(mk(0, 1, 32'd0, 0, 0, 0, 32'd1));
        tbl.push_back(mk(0, 1, 32'd1, 0, 0, 0, 32'd2));
        tbl.push_back(mk(0, 1, 32'd2, 0, 0, 0, 32'd3));
        tbl.push_back(mk(0, 1, 32'd3, 0, 0, 0, 32'd4));
        tbl.push_back(mk(0, 1, 32'd4, 1, 0, 0, 32'd5));
        tbl.push_back(mk(0, 1, 32'd10, 0, 1, 1, 32'd11));
        tbl.push_back(mk(0, 1, 32'd11, 0, 0, 1, 32'd12));
        tbl.push_back(mk(0, 1, 32'd12, 0, 0, 1, 32'd13));
        tbl.push_back(mk(0, 1, 32'd13, 0, 0, 1, 32'd14));
        tbl.push_back(mk(0, 1, 32'd14, 1, 0, 1, 32'd15));
        tbl.push_back(mk(0, 1, 32'd15, 1, 0, 1, 32'd16));
        tbl.push_back(mk(1, 0, 32'd0, 0, 0, 0, 32'd0));
        tbl.push_back(mk(0, 1, 32'd2, 0, 0, 0, 32'd3));
        tbl.push_back(mk(0, 1, 32'd3, 0, 0, 0, 32'd4));
        tbl.push_back(mk(0, 1, 32'd4, 0, 0, 0, 32'd5));
        tbl.push_back(mk(0, 1, 32'd5, 0, 0, 0, 32'd6));
        tbl.push_back(mk(0, 1, 32'd6, 1, 0, 0, 32'd7));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 32'hDEADBEEF, 1, 0, 0, 32'd7));
        tbl.push_back(mk(0, 1, 32'd7, 1, 0, 0, 32'd8));
        tbl.push_back(mk(0, 1, 32'd100, 0, 1, 1, 32'd101));
        tbl.push_back(mk(0, 1, 32'd200, 0, 0, 1, 32'd201));
        tbl.push_back(mk(1, 0, 32'd0, 0, 0, 0, 32'd0));
        tbl.push_back(mk(0, 1, 32'hFFFFFFFD, 0, 0, 0, 32'hFFFFFFFE));
        tbl.push_back(mk(0, 1, 32'hFFFFFFFE, 0, 0, 0, 32'hFFFFFFFF));
        tbl.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h00000000));
        tbl.push_back(mk(0, 1, 32'h00000000, 0, 0, 0, 32'h00000001));
        tbl.push_back(mk(0, 1, 32'h00000001, 1, 0, 0, 32'h00000002));
        tbl.push_back(mk(0, 1, 32'h00000002, 1, 0, 0, 32'h00000003));
`ifndef COUNT_CHECKER_STUCK_EN
        tbl.push_back(mk(0, 1, 32'h00000002, 0, 1, 1, 32'h00000003));
        tbl.push_back(mk(0, 1, 32'h00000003, 0, 0, 1, 32'h00000004));
`endif

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r;
            v   = tbl[i].v;
            d   = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d locked", i), 32'(locked), 32'(tbl[i].lk));
            chk($sformatf("row%0d err_pulse", i), 32'(err_pulse), 32'(tbl[i].ep));
            chk($sformatf("row%0d err_count", i), 32'(err_count), 32'(tbl[i].ec));
            chk($sformatf("row%0d expected", i), expected, tbl[i].ex);
        end

        // Reset between edges must clear outputs before the next rising edge.
        @(negedge clk);
        v = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async locked", 32'(locked), 0);
        chk("async err_pulse", 32'(err_pulse), 0);
        chk("async err_count", 32'(err_count), 0);
        chk("async expected", expected, 0);
        @(negedge clk);
        rst = 1'b0;

        step2(32'd0);
        for (int k = 0; k < 5; k++) begin
            for (int j = 1; j <= 4; j++)
                step2(32'(k * 100 + j));
            chk($sformatf("sat%0d locked", k), 32'(locked2), 1);
            step2(32'(k * 100 + 100));
            chk($sformatf("sat%0d err_pulse", k), 32'(err2), 1);
            chk($sformatf("sat%0d err_count", k), 32'(cnt2), 32'(k + 1 > 3 ? 3 : k + 1));
        end

`ifdef COUNT_CHECKER_STUCK_EN
        @(negedge clk);
        rst = 1'b1;
        v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 4; j <= 8; j++)
            step(1'b1, 32'(j));
        chk("pre-stuck locked", 32'(locked), 1);
        chk("pre-stuck expected", expected, 9);
        step(1'b1, 32'd8);
        chk("stuck set", 32'(stuck), 1);
        chk("stuck err_pulse", 32'(err_pulse), 0);
        chk("stuck locked", 32'(locked), 1);
        chk("stuck expected", expected, 9);
        chk("stuck err_count", 32'(err_count), 0);
        step(1'b1, 32'd9);
        chk("stuck clear", 32'(stuck), 0);
        chk("stuck resume expected", expected, 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
